// File: rtl/riscv_multicycle_controller.sv
// riscv_multicycle_controller
// Moore control FSM for a multicycle RV32I datapath that shares one memory
// and one ALU. Each instruction walks FETCH -> DECODE -> class-specific
// states, taking 3 to 5 cycles plus MEM_WAIT extra cycles per memory access.
//
// Parameters:
//   MEM_WAIT      extra wait cycles per memory access (0..15)
//   ILLEGAL_HALT  1: an illegal instruction parks the FSM in TRAP until reset
//                 0: an illegal instruction is skipped with a one-cycle pulse
//
// Ports:
//   clk, rst                rising-edge clock, synchronous active-high reset
//   op, func3, func7        instruction fields from IR
//   cond                    branch condition computed by the datapath
//   pc_write, ir_write      PC / IR+OldPC load enables
//   adr_src                 memory address select (0 PC, 1 ALUOut)
//   mem_write, reg_write    data memory / register file write strobes
//   result_src              00 ALUOut, 01 mem data, 10 ALU result, 11 imm
//   alu_src_a, alu_src_b    ALU operand selects
//   imm_src                 immediate format (000 I .. 100 J)
//   alu_control             ALU operation
//   state_o                 current FSM state (debug)
//   instr_done              high on the final cycle of an instruction
//   illegal                 illegal-instruction indicator
module riscv_multicycle_controller #(
  parameter int unsigned MEM_WAIT     = 0,
  parameter bit          ILLEGAL_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       cond,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic [2:0] alu_control,
  output logic [3:0] state_o,
  output logic       instr_done,
  output logic       illegal
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXEC_R   = 4'd6;
  localparam logic [3:0] S_EXEC_I   = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JUMP     = 4'd10;
  localparam logic [3:0] S_JALR_ADR = 4'd11;
  localparam logic [3:0] S_LUI      = 4'd12;
  localparam logic [3:0] S_TRAP     = 4'd13;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  logic [3:0] state;
  logic [3:0] state_nx;
  logic [3:0] wait_cnt;
  logic       trap_flag;
  logic       mem_state;
  logic       wait_last;
  logic       op_legal;
  logic       f3_ok;
  logic       f7_sub;
  logic       r_ok;
  logic       illegal_now;
  logic [2:0] alu_f3;
  logic [2:0] imm_dec;

  // op/func3/func7 come straight from IR, which only changes on ir_write at
  // the end of FETCH, so they act as latched decode for the rest of the
  // instruction.
  assign mem_state = (state == S_FETCH) || (state == S_MEMREAD) ||
                     (state == S_MEMWRITE);
  assign wait_last = (wait_cnt == WAIT_LAST);

  always_comb begin
    op_legal = 1'b0;
    case (op)
      OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI:
        op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  end

  always_comb begin
    imm_dec = 3'b000;
    case (op)
      OP_STORE: imm_dec = 3'b001;
      OP_BR:    imm_dec = 3'b010;
      OP_LUI:   imm_dec = 3'b011;
      OP_JAL:   imm_dec = 3'b100;
      default:  imm_dec = 3'b000;
    endcase
  end

  // Shared func3 -> ALU mapping for R and I forms; shifts are not supported.
  always_comb begin
    f3_ok  = 1'b1;
    alu_f3 = ALU_ADD;
    case (func3)
      3'b000:  alu_f3 = ALU_ADD;
      3'b010:  alu_f3 = ALU_SLT;
      3'b011:  alu_f3 = ALU_SLTU;
      3'b100:  alu_f3 = ALU_XOR;
      3'b110:  alu_f3 = ALU_OR;
      3'b111:  alu_f3 = ALU_AND;
      default: f3_ok  = 1'b0;
    endcase
  end

  assign f7_sub = (func7 == 7'b0100000) && (func3 == 3'b000);
  assign r_ok   = f3_ok && ((func7 == 7'b0000000) || f7_sub);

  assign illegal_now = ((state == S_DECODE) && !op_legal) ||
                       ((state == S_EXEC_R) && !r_ok) ||
                       ((state == S_EXEC_I) && !f3_ok);

  always_comb begin
    state_nx = S_FETCH;
    case (state)
      S_FETCH:    state_nx = wait_last ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_nx = S_MEMADR;
          OP_R:              state_nx = S_EXEC_R;
          OP_I:              state_nx = S_EXEC_I;
          OP_BR:             state_nx = S_BRANCH;
          OP_JAL:            state_nx = S_JUMP;
          OP_JALR:           state_nx = S_JALR_ADR;
          OP_LUI:            state_nx = S_LUI;
          default:           state_nx = S_FETCH;
        endcase
      end
      S_MEMADR:   state_nx = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_nx = wait_last ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_nx = S_FETCH;
      S_MEMWRITE: state_nx = wait_last ? S_FETCH : S_MEMWRITE;
      S_EXEC_R:   state_nx = S_ALUWB;
      S_EXEC_I:   state_nx = S_ALUWB;
      S_ALUWB:    state_nx = S_FETCH;
      S_BRANCH:   state_nx = S_FETCH;
      S_JUMP:     state_nx = S_ALUWB;
      S_JALR_ADR: state_nx = S_JUMP;
      S_LUI:      state_nx = S_FETCH;
      S_TRAP:     state_nx = S_TRAP;
      default:    state_nx = S_FETCH;
    endcase
    if (illegal_now) begin
      state_nx = ILLEGAL_HALT ? S_TRAP : S_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      wait_cnt  <= 4'd0;
      trap_flag <= 1'b0;
    end else begin
      state <= state_nx;
      // Counter only runs while a memory state is being held; leaving the
      // state (on its last wait cycle) returns it to zero.
      if (mem_state && !wait_last) begin
        wait_cnt <= wait_cnt + 4'd1;
      end else begin
        wait_cnt <= 4'd0;
      end
      if (state_nx == S_TRAP) begin
        trap_flag <= 1'b1;
      end
    end
  end

  always_comb begin
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    imm_src     = 3'b000;
    alu_control = ALU_ADD;
    instr_done  = 1'b0;
    case (state)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_write   = wait_last;
        ir_write   = wait_last;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = imm_dec;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = imm_dec;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        instr_done = wait_last;
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        if (r_ok) begin
          alu_control = f7_sub ? ALU_SUB : alu_f3;
        end
      end
      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        if (f3_ok) begin
          alu_control = alu_f3;
        end
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        pc_write    = cond;
        instr_done  = 1'b1;
      end
      S_JUMP: begin
        // PC takes the target already in ALUOut while the ALU forms OldPC+4.
        pc_write  = 1'b1;
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
      end
      S_JALR_ADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_LUI: begin
        imm_src    = 3'b011;
        result_src = 2'b11;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    // An instruction interrupted by reset must not leave any strobe behind.
    if (rst) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      instr_done = 1'b0;
    end
  end

  assign state_o = state;
  assign illegal = trap_flag || (!ILLEGAL_HALT && illegal_now);

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// Testbench for riscv_multicycle_controller. Three instances cover
// (MEM_WAIT, ILLEGAL_HALT) = (0,1), (2,0), (3,1).
module tb_riscv_multicycle_controller;

  localparam logic [3:0] ST_FETCH    = 4'd0;
  localparam logic [3:0] ST_DECODE   = 4'd1;
  localparam logic [3:0] ST_MEMADR   = 4'd2;
  localparam logic [3:0] ST_MEMREAD  = 4'd3;
  localparam logic [3:0] ST_MEMWB    = 4'd4;
  localparam logic [3:0] ST_MEMWRITE = 4'd5;
  localparam logic [3:0] ST_EXEC_R   = 4'd6;
  localparam logic [3:0] ST_EXEC_I   = 4'd7;
  localparam logic [3:0] ST_ALUWB    = 4'd8;
  localparam logic [3:0] ST_BRANCH   = 4'd9;
  localparam logic [3:0] ST_JUMP     = 4'd10;
  localparam logic [3:0] ST_JALR_ADR = 4'd11;
  localparam logic [3:0] ST_LUI      = 4'd12;
  localparam logic [3:0] ST_TRAP     = 4'd13;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_BAD   = 7'b1111111;
  localparam logic [6:0] F7_SUB   = 7'b0100000;

  typedef struct packed {
    logic [3:0] state;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] imm_src;
    logic [2:0] alu_control;
    logic       instr_done;
    logic       illegal;
  } out_t;

  localparam int W = $bits(out_t);

  typedef struct {
    logic [6:0]      op;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic            cond;
    int              cycles;
    logic [4:0][3:0] st;
    logic [2:0]      alu3;
    logic            pcw3;
  } vec_t;

  // ---------------- clock / reset / DUTs ----------------
  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_v   [3];
  logic [6:0] op_v    [3];
  logic [2:0] f3_v    [3];
  logic [6:0] f7_v    [3];
  logic       cond_v  [3];
  logic       pcw_v   [3];
  logic       adr_v   [3];
  logic       memw_v  [3];
  logic       irw_v   [3];
  logic       regw_v  [3];
  logic [1:0] res_v   [3];
  logic [1:0] a_v     [3];
  logic [1:0] b_v     [3];
  logic [2:0] imm_v   [3];
  logic [2:0] alu_v   [3];
  logic [3:0] state_v [3];
  logic       done_v  [3];
  logic       ill_v   [3];

  int mw_of   [3] = '{0, 2, 3};
  bit halt_of [3] = '{1'b1, 1'b0, 1'b1};

  riscv_multicycle_controller #(.MEM_WAIT(0), .ILLEGAL_HALT(1'b1)) u_dut0 (
    .clk(clk), .rst(rst_v[0]), .op(op_v[0]), .func3(f3_v[0]), .func7(f7_v[0]),
    .cond(cond_v[0]), .pc_write(pcw_v[0]), .adr_src(adr_v[0]),
    .mem_write(memw_v[0]), .ir_write(irw_v[0]), .reg_write(regw_v[0]),
    .result_src(res_v[0]), .alu_src_a(a_v[0]), .alu_src_b(b_v[0]),
    .imm_src(imm_v[0]), .alu_control(alu_v[0]), .state_o(state_v[0]),
    .instr_done(done_v[0]), .illegal(ill_v[0])
  );

  riscv_multicycle_controller #(.MEM_WAIT(2), .ILLEGAL_HALT(1'b0)) u_dut1 (
    .clk(clk), .rst(rst_v[1]), .op(op_v[1]), .func3(f3_v[1]), .func7(f7_v[1]),
    .cond(cond_v[1]), .pc_write(pcw_v[1]), .adr_src(adr_v[1]),
    .mem_write(memw_v[1]), .ir_write(irw_v[1]), .reg_write(regw_v[1]),
    .result_src(res_v[1]), .alu_src_a(a_v[1]), .alu_src_b(b_v[1]),
    .imm_src(imm_v[1]), .alu_control(alu_v[1]), .state_o(state_v[1]),
    .instr_done(done_v[1]), .illegal(ill_v[1])
  );

  riscv_multicycle_controller #(.MEM_WAIT(3), .ILLEGAL_HALT(1'b1)) u_dut2 (
    .clk(clk), .rst(rst_v[2]), .op(op_v[2]), .func3(f3_v[2]), .func7(f7_v[2]),
    .cond(cond_v[2]), .pc_write(pcw_v[2]), .adr_src(adr_v[2]),
    .mem_write(memw_v[2]), .ir_write(irw_v[2]), .reg_write(regw_v[2]),
    .result_src(res_v[2]), .alu_src_a(a_v[2]), .alu_src_b(b_v[2]),
    .imm_src(imm_v[2]), .alu_control(alu_v[2]), .state_o(state_v[2]),
    .instr_done(done_v[2]), .illegal(ill_v[2])
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int vectors    = 0;
  int miscompares = 0;

  function automatic out_t get_act(input int k);
    out_t a;
    a.state       = state_v[k];
    a.pc_write    = pcw_v[k];
    a.adr_src     = adr_v[k];
    a.mem_write   = memw_v[k];
    a.ir_write    = irw_v[k];
    a.reg_write   = regw_v[k];
    a.result_src  = res_v[k];
    a.alu_src_a   = a_v[k];
    a.alu_src_b   = b_v[k];
    a.imm_src     = imm_v[k];
    a.alu_control = alu_v[k];
    a.instr_done  = done_v[k];
    a.illegal     = ill_v[k];
    return a;
  endfunction

  task automatic check_rec(input int k, input out_t e_in, input string name);
    out_t a;
    out_t e;
    a = get_act(k);
    e = e_in;
    // The immediate format during address generation is left unconstrained.
    if (e.state == ST_MEMADR) e.imm_src = a.imm_src;
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s inst%0d t=%0t: got state=%0d outs=%h required state=%0d outs=%h",
               name, k, $time, a.state, a, e.state, e);
    end
  endtask

  task automatic check_val(input string name, input int k, input int got, input int req);
    vectors++;
    if (got != req) begin
      miscompares++;
      $display("FAIL %s inst%0d t=%0t: got %0d required %0d", name, k, $time, got, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic out_t blank(input logic [3:0] s);
    out_t r;
    r = '0;
    r.state = s;
    return r;
  endfunction

  function automatic bit op_known(input logic [6:0] op);
    logic [6:0] legal_ops[8];
    legal_ops = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI};
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [2:0] imm_for(input logic [6:0] op);
    if (op == OP_STORE) return 3'd1;
    if (op == OP_BR)    return 3'd2;
    if (op == OP_LUI)   return 3'd3;
    if (op == OP_JAL)   return 3'd4;
    return 3'd0;
  endfunction

  // ALU code for a func3, or -1 when func3 is not a supported operation.
  function automatic int f3_alu(input logic [2:0] f3);
    int tbl[8];
    tbl = '{0, -1, 5, 6, 4, -1, 3, 2};
    return tbl[f3];
  endfunction

  task automatic push(input out_t r);
    exp_q.push_back(r);
  endtask

  task automatic push_aluwb();
    out_t r;
    r = blank(ST_ALUWB);
    r.reg_write = 1'b1;
    r.instr_done = 1'b1;
    push(r);
  endtask

  task automatic push_trap(input int n);
    out_t r;
    for (int i = 0; i < n; i++) begin
      r = blank(ST_TRAP);
      r.illegal = 1'b1;
      push(r);
    end
  endtask

  task automatic build(input int k, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic cond, input int trap_len,
                       output bit trapped);
    out_t r;
    int   mw;
    bit   halt;
    int   code;
    bit   ok;
    mw = mw_of[k];
    halt = halt_of[k];
    trapped = 1'b0;
    for (int i = 0; i <= mw; i++) begin
      r = blank(ST_FETCH);
      r.alu_src_b = 2'd2;
      r.result_src = 2'd2;
      r.pc_write = (i == mw);
      r.ir_write = (i == mw);
      push(r);
    end
    r = blank(ST_DECODE);
    r.alu_src_a = 2'd1;
    r.alu_src_b = 2'd1;
    r.imm_src = imm_for(op);
    if (!op_known(op)) begin
      r.illegal = !halt;
      push(r);
      if (halt) begin
        push_trap(trap_len);
        trapped = 1'b1;
      end
      return;
    end
    push(r);
    code = f3_alu(f3);
    if (op == OP_LOAD || op == OP_STORE) begin
      r = blank(ST_MEMADR);
      r.alu_src_a = 2'd2;
      r.alu_src_b = 2'd1;
      push(r);
      for (int i = 0; i <= mw; i++) begin
        r = blank(op == OP_LOAD ? ST_MEMREAD : ST_MEMWRITE);
        r.adr_src = 1'b1;
        if (op == OP_STORE) begin
          r.mem_write = 1'b1;
          r.instr_done = (i == mw);
        end
        push(r);
      end
      if (op == OP_LOAD) begin
        r = blank(ST_MEMWB);
        r.result_src = 2'd1;
        r.reg_write = 1'b1;
        r.instr_done = 1'b1;
        push(r);
      end
    end else if (op == OP_R || op == OP_I) begin
      r = blank(op == OP_R ? ST_EXEC_R : ST_EXEC_I);
      r.alu_src_a = 2'd2;
      r.alu_src_b = (op == OP_I) ? 2'd1 : 2'd0;
      if (op == OP_R) ok = (code >= 0) && (f7 == 7'd0 || (f7 == F7_SUB && f3 == 3'd0));
      else            ok = (code >= 0);
      if (ok) begin
        r.alu_control = (op == OP_R && f7 == F7_SUB) ? 3'd1 : 3'(code);
        push(r);
        push_aluwb();
      end else begin
        r.illegal = !halt;
        push(r);
        if (halt) begin
          push_trap(trap_len);
          trapped = 1'b1;
        end
      end
    end else if (op == OP_BR) begin
      r = blank(ST_BRANCH);
      r.alu_src_a = 2'd2;
      r.alu_control = 3'd1;
      r.pc_write = cond;
      r.instr_done = 1'b1;
      push(r);
    end else if (op == OP_LUI) begin
      r = blank(ST_LUI);
      r.imm_src = 3'd3;
      r.result_src = 2'd3;
      r.reg_write = 1'b1;
      r.instr_done = 1'b1;
      push(r);
    end else begin
      if (op == OP_JALR) begin
        r = blank(ST_JALR_ADR);
        r.alu_src_a = 2'd2;
        r.alu_src_b = 2'd1;
        push(r);
      end
      r = blank(ST_JUMP);
      r.pc_write = 1'b1;
      r.alu_src_a = 2'd1;
      r.alu_src_b = 2'd2;
      push(r);
      push_aluwb();
    end
  endtask

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic set_inst(input int k, input logic [6:0] op, input logic [2:0] f3,
                          input logic [6:0] f7, input logic cond);
    op_v[k] = op;
    f3_v[k] = f3;
    f7_v[k] = f7;
    cond_v[k] = cond;
  endtask

  task automatic begin_test(input int k);
    rst_v[k] = 1'b1;
    @(posedge clk);
    #1;
    rst_v[k] = 1'b0;
  endtask

  task automatic run_trace(input int k, input string name);
    out_t e;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = out_t'(exp_q.pop_front());
      check_rec(k, e, name);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic trap_reset(input int k);
    out_t r;
    rst_v[k] = 1'b1;
    @(negedge clk);
    r = blank(ST_TRAP);
    r.illegal = 1'b1;
    check_rec(k, r, "trap_rst_cycle");
    @(posedge clk);
    #1;
    rst_v[k] = 1'b0;
  endtask

  task automatic do_instr(input int k, input logic [6:0] op, input logic [2:0] f3,
                          input logic [6:0] f7, input logic cond, input int trap_len,
                          input string name);
    bit trapped;
    set_inst(k, op, f3, f7, cond);
    build(k, op, f3, f7, cond, trap_len, trapped);
    run_trace(k, name);
    if (trapped) trap_reset(k);
  endtask

  function automatic logic [4:0][3:0] seq5(input logic [3:0] s0, input logic [3:0] s1,
                                          input logic [3:0] s2, input logic [3:0] s3,
                                          input logic [3:0] s4);
    logic [4:0][3:0] r;
    r[0] = s0; r[1] = s1; r[2] = s2; r[3] = s3; r[4] = s4;
    return r;
  endfunction

  // ---------------- main sequence ----------------
  vec_t tbl[14];

  initial begin
    out_t r;
    int   cyc;
    bit   seen;
    bit   trapped;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    int   cls;

    // MEM_WAIT=0 expectations: {op, f3, f7, cond, cycles, states, alu@cycle2, pc_write@cycle2}
    tbl[0]  = '{OP_R,     3'b000, 7'd0,   1'b0, 4, seq5(0, 1, 6, 8, 0),   3'b000, 1'b0};
    tbl[1]  = '{OP_R,     3'b000, F7_SUB, 1'b0, 4, seq5(0, 1, 6, 8, 0),   3'b001, 1'b0};
    tbl[2]  = '{OP_R,     3'b010, 7'd0,   1'b0, 4, seq5(0, 1, 6, 8, 0),   3'b101, 1'b0};
    tbl[3]  = '{OP_I,     3'b111, 7'd0,   1'b0, 4, seq5(0, 1, 7, 8, 0),   3'b010, 1'b0};
    tbl[4]  = '{OP_I,     3'b110, 7'd0,   1'b0, 4, seq5(0, 1, 7, 8, 0),   3'b011, 1'b0};
    tbl[5]  = '{OP_I,     3'b011, 7'd0,   1'b0, 4, seq5(0, 1, 7, 8, 0),   3'b110, 1'b0};
    tbl[6]  = '{OP_I,     3'b100, F7_SUB, 1'b0, 4, seq5(0, 1, 7, 8, 0),   3'b100, 1'b0};
    tbl[7]  = '{OP_LOAD,  3'b010, 7'd0,   1'b0, 5, seq5(0, 1, 2, 3, 4),   3'b000, 1'b0};
    tbl[8]  = '{OP_STORE, 3'b010, 7'd0,   1'b0, 4, seq5(0, 1, 2, 5, 0),   3'b000, 1'b0};
    tbl[9]  = '{OP_BR,    3'b000, 7'd0,   1'b1, 3, seq5(0, 1, 9, 0, 0),   3'b001, 1'b1};
    tbl[10] = '{OP_BR,    3'b000, 7'd0,   1'b0, 3, seq5(0, 1, 9, 0, 0),   3'b001, 1'b0};
    tbl[11] = '{OP_JAL,   3'b000, 7'd0,   1'b0, 4, seq5(0, 1, 10, 8, 0),  3'b000, 1'b1};
    tbl[12] = '{OP_JALR,  3'b000, 7'd0,   1'b0, 5, seq5(0, 1, 11, 10, 8), 3'b000, 1'b0};
    tbl[13] = '{OP_LUI,   3'b000, 7'd0,   1'b0, 3, seq5(0, 1, 12, 0, 0),  3'b000, 1'b0};

    for (int k = 0; k < 3; k++) begin
      rst_v[k] = 1'b1;
      set_inst(k, 7'd0, 3'd0, 7'd0, 1'b0);
    end
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;

    // Reset state: FETCH, no strobes even though FETCH's last wait cycle is active.
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      r = blank(ST_FETCH);
      r.alu_src_b = 2'd2;
      r.result_src = 2'd2;
      check_rec(k, r, "reset_state");
    end
    @(posedge clk);
    #1;

    // Table-driven single-instruction checks on the MEM_WAIT=0 instance.
    begin_test(0);
    for (int v = 0; v < 14; v++) begin
      set_inst(0, tbl[v].op, tbl[v].f3, tbl[v].f7, tbl[v].cond);
      for (int c = 0; c < tbl[v].cycles; c++) begin
        @(negedge clk);
        check_val("tbl_state", 0, int'(state_v[0]), int'(tbl[v].st[c]));
        check_val("tbl_done", 0, int'(done_v[0]), (c == tbl[v].cycles - 1) ? 1 : 0);
        if (c == 2) begin
          check_val("tbl_alu", 0, int'(alu_v[0]), int'(tbl[v].alu3));
          check_val("tbl_pc_write", 0, int'(pcw_v[0]), int'(tbl[v].pcw3));
        end
        @(posedge clk);
        #1;
      end
    end

    // Illegal opcode with halting: 20 cycles in TRAP, then reset recovers.
    do_instr(0, OP_BAD, 3'd0, 7'd0, 1'b0, 20, "halt_illegal");
    do_instr(0, OP_R, 3'd0, 7'd0, 1'b0, 0, "after_trap_add");

    // Load with MEM_WAIT=2 through the model, then an explicit cycle count.
    begin_test(1);
    do_instr(1, OP_LOAD, 3'b010, 7'd0, 1'b0, 0, "lw_mw2");
    set_inst(1, OP_LOAD, 3'b010, 7'd0, 1'b0);
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      seen = done_v[1];
      @(posedge clk);
      #1;
    end
    check_val("lw_mw2_cycles", 1, cyc, 9);

    // Skip mode: illegal opcode and unsupported shift each pulse and return to FETCH.
    do_instr(1, OP_BAD, 3'd0, 7'd0, 1'b0, 0, "skip_bad_op");
    do_instr(1, OP_R, 3'b001, 7'd0, 1'b0, 0, "skip_shift_r");
    do_instr(1, OP_I, 3'b101, 7'd0, 1'b0, 0, "skip_shift_i");
    do_instr(1, OP_R, 3'b000, F7_SUB, 1'b0, 0, "after_skip_sub");

    // Reset in the third MEMWRITE wait cycle with MEM_WAIT=3.
    begin_test(2);
    set_inst(2, OP_STORE, 3'b010, 7'd0, 1'b0);
    build(2, OP_STORE, 3'b010, 7'd0, 1'b0, 0, trapped);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    run_trace(2, "sw_before_rst");
    rst_v[2] = 1'b1;
    @(negedge clk);
    r = blank(ST_MEMWRITE);
    r.adr_src = 1'b1;
    check_rec(2, r, "rst_in_memwrite");
    @(posedge clk);
    #1;
    rst_v[2] = 1'b0;
    // A full four-cycle FETCH afterwards shows the wait counter restarted at 0.
    do_instr(2, OP_I, 3'b000, 7'd0, 1'b0, 0, "after_rst_addi");

    // Randomized instruction streams on every instance.
    for (int k = 0; k < 3; k++) begin
      begin_test(k);
      for (int n = 0; n < 40; n++) begin
        cls = $urandom_range(0, 9);
        f3 = 3'($urandom_range(0, 7));
        f7 = 7'd0;
        case (cls)
          0: op = OP_LOAD;
          1: op = OP_STORE;
          2: begin
            op = OP_R;
            case ($urandom_range(0, 3))
              0, 1: f7 = 7'd0;
              2:    f7 = F7_SUB;
              default: f7 = 7'($urandom_range(0, 127));
            endcase
          end
          3: begin op = OP_I; f7 = 7'($urandom_range(0, 127)); end
          4: op = OP_BR;
          5: op = OP_JAL;
          6: op = OP_JALR;
          7: op = OP_LUI;
          default: begin
            op = 7'($urandom_range(0, 127));
            if (op_known(op)) op = OP_BAD;
          end
        endcase
        do_instr(k, op, f3, f7, 1'($urandom_range(0, 1)), 3, "random");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/riscv_multicycle_controller.md
Name: riscv_multicycle_controller

Overview:
Multicycle RV32I control unit: a Moore FSM that sequences a shared-memory, single-ALU datapath over 3–5+ cycles per instruction. It replaces the per-instruction combinational decode with a state machine. A parameter inserts memory wait states. Illegal-instruction handling is selectable between halting and skipping.

Parameters:
MEM_WAIT, 0, extra wait cycles for each memory access (fetch, load, store); range 0–15
ILLEGAL_HALT, 1, 1 = illegal instruction enters sticky TRAP; 0 = skip it (one-cycle illegal pulse, then FETCH)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
op  in  7  instruction opcode (IR[6:0])
func3  in  3  IR[14:12]
func7  in  7  IR[31:25]
cond  in  1  branch condition evaluated by datapath for func3
pc_write  out  1  PC register load enable
adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_write  out  1  data memory write strobe
ir_write  out  1  IR and OldPC load enable
reg_write  out  1  register file write enable
result_src  out  2  00 ALUOut, 01 mem data, 10 ALU result, 11 immediate
alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1
alu_src_b  out  2  00 rs2, 01 imm, 10 constant 4
imm_src  out  3  000 I, 001 S, 010 B, 011 U, 100 J
alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sltu
state_o  out  4  current state (debug)
instr_done  out  1  high on an instruction's final cycle
illegal  out  1  illegal-instruction indicator

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXEC_R=6, EXEC_I=7, ALUWB=8, BRANCH=9, JUMP=10, JALR_ADR=11, LUI=12, TRAP=13. Codes 14–15 go to FETCH.
- Outputs are Moore (functions of state plus latched decode), except pc_write in BRANCH = cond.
- Unlisted outputs are 0.
- Reset: on a clk edge with rst=1, state←FETCH, wait counter←0, illegal←0. While rst=1, pc_write, ir_write, mem_write, reg_write and instr_done are forced 0. Reset mid-instruction abandons it with no further strobes.
- Wait counter (4 bit) applies in FETCH, MEMREAD and MEMWRITE. The state is held for MEM_WAIT+1 cycles; the counter clears on exit.
- FETCH: adr_src=0, a=00, b=10, add, result_src=10. ir_write=pc_write=1 on the final wait cycle only. Then → DECODE.
- DECODE: a=01, b=01, add; imm_src per opcode.
  - Opcode 0000011 or 0100011 → MEMADR.
  - 0110011 → EXEC_R; 0010011 → EXEC_I; 1100011 → BRANCH.
  - 1101111 → JUMP; 1100111 → JALR_ADR; 0110111 → LUI.
  - Otherwise illegal.
- MEMADR: a=10, b=01, add. Load → MEMREAD; store → MEMWRITE.
- MEMREAD: adr_src=1. → MEMWB.
- MEMWB: result_src=01, reg_write=1, done. → FETCH.
- MEMWRITE: adr_src=1, mem_write=1 on every wait cycle, done on final cycle. → FETCH.
- EXEC_R: a=10, b=00. alu_control from func3/func7:
  - func7=0000000: 000 add, 010 slt, 011 sltu, 100 xor, 110 or, 111 and.
  - func7=0100000 with func3=000: sub.
  - Anything else (including shift func3 001/101) is illegal.
  - → ALUWB.
- EXEC_I: a=10, b=01, imm I. Same func3 mapping; func3 001/101 illegal. → ALUWB.
- ALUWB: result_src=00, reg_write=1, done. → FETCH.
- BRANCH: a=10, b=00, sub, result_src=00, pc_write=cond, done. → FETCH.
- JALR_ADR: a=10, b=01, imm I, add. → JUMP.
- JUMP: result_src=00, pc_write=1, a=01, b=10, add (ALUOut←OldPC+4). → ALUWB.
- LUI: imm U, result_src=11, reg_write=1, done. → FETCH.
- Illegal handling, detected in DECODE, EXEC_R or EXEC_I:
  - ILLEGAL_HALT=1: → TRAP. illegal=1 sticky; all strobes 0; only rst exits.
  - ILLEGAL_HALT=0: illegal pulses one cycle, no register or memory write, → FETCH.
- Cycle counts with MEM_WAIT=0: R/I-ALU 4, load 5, store 4, branch 3, jal 4, jalr 5, lui 3. Add MEM_WAIT for each memory-access state visited.

Test Plan:
- MEM_WAIT=0, add (op 0110011, f3 000, f7 0) → states 0,1,6,8. alu_control=000 in EXEC_R; reg_write only in ALUWB; instr_done at cycle 4.
- MEM_WAIT=2, lw (0000011) → FETCH holds 3 cycles with ir_write only on the 3rd; MEMREAD holds 3; MEMWB reg_write=1 with result_src=01; total 9 cycles.
- beq (1100011): cond=1 → pc_write=1 in BRANCH with alu_control=001. Repeat with cond=0 → pc_write=0; both take 3 cycles.
- jalr (1100111) → states 0,1,11,10,8. In JUMP, pc_write=1 and result_src=00; in ALUWB, reg_write=1.
- op 1111111: ILLEGAL_HALT=1 → state 13, illegal stays 1 for 20 cycles, no strobes; rst → FETCH, illegal=0. With ILLEGAL_HALT=0 → illegal pulses 1 cycle, then FETCH.
- rst asserted in MEMWRITE with MEM_WAIT=3 → mem_write drops in the rst cycle; next state FETCH, counter 0.
